// File: rtl/sort_result_serializer_if.sv
// Stream bundle for the sort result serializer: vector input side and element output side.
// The DUT takes the slave view; the feeding/consuming environment takes the master view.
interface sort_result_serializer_if #(
   parameter int DATA_W = 4,
   parameter int DATA_N = 4
);
   logic                           in_valid;
   logic                           in_ready;
   logic [DATA_N-1:0][DATA_W-1:0]  data_in;
   logic                           out_valid;
   logic                           out_ready;
   logic [DATA_W-1:0]              out_data;
   logic [$clog2(DATA_N)-1:0]      out_idx;
   logic                           out_last;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/sort_result_serializer.sv
// Captures sorted vectors into a 2-entry ping-pong FIFO and emits them one element per cycle
// (first element the cycle after the push); holds output under backpressure, flags order violations.
module sort_result_serializer #(
   parameter int DATA_W = 4,
   parameter int DATA_N = 4,
   parameter int ASCEND = 1,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sort_result_serializer_if.slave io,
   output logic                  order_err,
   output logic [CNT_W-1:0]      vec_cnt
);
   localparam int IDX_W = $clog2(DATA_N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_N - 1);

   logic [1:0][DATA_N-1:0][DATA_W-1:0] entry;
   logic [1:0]        count;
   logic [1:0]        count_next;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] prev;
   logic              push;
   logic              xfer;
   logic              pop;
   logic              violation;

   assign push = io.in_valid && io.in_ready;
   assign xfer = io.out_valid && io.out_ready;
   assign pop  = xfer && (idx == LAST_IDX);

   always_comb begin
      count_next = count + {1'b0, push} - {1'b0, pop};
   end

   assign io.out_valid = (count != 2'd0);
   assign io.out_data  = entry[rd_ptr][idx];
   assign io.out_idx   = idx;
   assign io.out_last  = io.out_valid && (idx == LAST_IDX);

   // Unsigned compare against the previously transferred element of the same vector.
   assign violation = (ASCEND != 0) ? (io.out_data < prev) : (io.out_data > prev);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entry       <= '0;
         count       <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         idx         <= '0;
         prev        <= '0;
         order_err   <= 1'b0;
         vec_cnt     <= '0;
         io.in_ready <= 1'b0;
      end else begin
         // Registered ready: a pop in the full cycle only reopens the input one cycle later.
         io.in_ready <= (count_next < 2'd2);
         count       <= count_next;
         if (push) begin
            entry[wr_ptr] <= io.data_in;
            wr_ptr        <= ~wr_ptr;
         end
         if (xfer) begin
            prev <= io.out_data;
            if ((idx != '0) && violation) begin
               order_err <= 1'b1;
            end
            if (pop) begin
               idx     <= '0;
               rd_ptr  <= ~rd_ptr;
               vec_cnt <= vec_cnt + CNT_W'(1);
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_sort_result_serializer.sv
// Randomized bench for sort_result_serializer against a queue-based model of the vector stream.
module tb_sort_result_serializer;
   localparam int DATA_W = 4;
   localparam int DATA_N = 4;
   localparam int ASCEND = 1;
   localparam int CNT_W  = 16;
   localparam int IDX_W  = $clog2(DATA_N);
   localparam int WW     = 1 + DATA_W + IDX_W + 3 + CNT_W;

   typedef logic [DATA_N-1:0][DATA_W-1:0] vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             order_err;
   logic [CNT_W-1:0] vec_cnt;
   int               checks = 0;
   int               failures = 0;

   sort_result_serializer_if #(.DATA_W(DATA_W), .DATA_N(DATA_N)) bus ();

   sort_result_serializer #(
      .DATA_W(DATA_W), .DATA_N(DATA_N), .ASCEND(ASCEND), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .io(bus.slave), .order_err(order_err), .vec_cnt(vec_cnt)
   );

   always #5 clk = ~clk;

   // Model: queue of whole vectors waiting or in flight, position within the head vector.
   vec_t mq[$];
   int   mpos = 0;
   bit   m_rdy = 0;
   bit   m_err = 0;
   int   m_cnt = 0;

   task automatic tick();
      bit xf, pu;
      logic [DATA_W-1:0] cur, prv;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete(); mpos = 0; m_rdy = 0; m_err = 0; m_cnt = 0;
      end else begin
         xf = (mq.size() != 0) && bus.out_ready;
         pu = bus.in_valid && m_rdy;
         if (xf) begin
            if (mpos > 0) begin
               cur = mq[0][mpos];
               prv = mq[0][mpos-1];
               if ((ASCEND != 0) ? (cur < prv) : (cur > prv)) m_err = 1;
            end
            if (mpos == DATA_N - 1) begin
               void'(mq.pop_front()); mpos = 0; m_cnt++;
            end else mpos++;
         end
         if (pu) mq.push_back(bus.data_in);
         m_rdy = (mq.size() < 2);
      end
      #1;
   endtask

   function automatic logic [WW-1:0] exp_word();
      logic [DATA_W-1:0] d = '0;
      bit v = (mq.size() != 0);
      if (v) d = mq[0][mpos];
      return {v, d, IDX_W'(mpos), v && (mpos == DATA_N - 1), m_rdy, m_err, CNT_W'(m_cnt)};
   endfunction

   function automatic logic [WW-1:0] obs_word();
      logic [DATA_W-1:0] d = '0;
      if (bus.out_valid) d = bus.out_data;
      return {bus.out_valid, d, bus.out_idx, bus.out_last, bus.in_ready, order_err, vec_cnt};
   endfunction

   function automatic vec_t sorted_vec(input vec_t v);
      int a[DATA_N];
      vec_t r;
      foreach (a[i]) a[i] = int'(v[i]);
      if (ASCEND != 0) a.sort(); else a.rsort();
      foreach (a[i]) r[i] = DATA_W'(a[i]);
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < DATA_N; i++) v[i] = DATA_W'($urandom);
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.data_in = rand_vec();
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.in_ready, order_err, vec_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got=%h want=0", c,
               {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.in_ready, order_err, vec_cnt});
         end
      end
      rst_n = 1'b1; bus.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release cyc=%0d in_ready=%b out_valid=%b want 1/0", c, bus.in_ready, bus.out_valid);
         end
      end
   endtask

   task automatic test_single();
      logic [DATA_W-1:0] got[$];
      int want[4] = '{1, 3, 7, 12};
      bus.in_valid = 1'b1; bus.data_in = {4'hC, 4'h7, 4'h3, 4'h1}; bus.out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         tick();
         bus.in_valid = 1'b0;
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL single cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
      end
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL single_count got=%0d want=4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(got[i]) != want[i]) begin
               failures++;
               $display("FAIL single_elem%0d got=%h want=%h", i, got[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] got[$];
      int want[8] = '{2, 4, 6, 8, 0, 5, 9, 15};
      vec_t vs[3];
      vs[0] = {4'h8, 4'h6, 4'h4, 4'h2};
      vs[1] = {4'hF, 4'h9, 4'h5, 4'h0};
      vs[2] = sorted_vec(rand_vec());
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.in_valid = 1'b1; bus.data_in = vs[c];
         tick();
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL bp_fill cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== 4'h2) begin
         failures++;
         $display("FAIL bp_full in_ready=%b out_data=%h want 0/2", bus.in_ready, bus.out_data);
      end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (bus.out_valid) got.push_back(bus.out_data);
         tick();
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL bp_drain cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
         if (c == 2 || c == 3) begin
            checks++;
            if (bus.in_ready !== (c == 3)) begin
               failures++;
               $display("FAIL bp_ready_rise cyc=%0d in_ready=%b want=%b", c, bus.in_ready, c == 3);
            end
         end
      end
      checks++;
      if (got.size() != 8) begin
         failures++;
         $display("FAIL bp_count got=%0d want=8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (int'(got[i]) != want[i]) begin
               failures++;
               $display("FAIL bp_elem%0d got=%h want=%h", i, got[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int drops = 0;
      logic [CNT_W-1:0] start = CNT_W'(m_cnt);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 44; c++) begin
         bus.in_valid = (c % 4 == 0) && (c < 40);
         bus.data_in  = sorted_vec(rand_vec());
         tick();
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL stream cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
         if (c < 40 && !bus.out_valid) drops++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (drops != 0) begin
         failures++;
         $display("FAIL stream_bubbles got=%0d want=0", drops);
      end
      checks++;
      if (vec_cnt - start !== CNT_W'(10)) begin
         failures++;
         $display("FAIL stream_vec_cnt got=%0d want=%0d", vec_cnt - start, 10);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = (c < 388) && ($urandom_range(1, 0) == 1);
         bus.out_ready = (c >= 388) || ($urandom_range(9, 0) < 7);
         bus.data_in   = sorted_vec(rand_vec());
         tick();
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_order_err();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         bus.in_valid = (c == 0) || (c == 6);
         bus.data_in  = (c == 0) ? {4'h1, 4'h9, 4'h3, 4'h2} : {4'hE, 4'hA, 4'h4, 4'h3};
         tick();
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL order cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
         if (c == 3 || c == 4 || c == 11) begin
            checks++;
            if (order_err !== (c != 3)) begin
               failures++;
               $display("FAIL order_flag cyc=%0d got=%b want=%b", c, order_err, c != 3);
            end
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.in_valid = 1'b1; bus.data_in = sorted_vec(rand_vec()); bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.out_idx !== IDX_W'(2) || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_setup idx=%0d valid=%b want 2/1", bus.out_idx, bus.out_valid);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || vec_cnt !== '0 || order_err !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset valid=%b vec_cnt=%0d err=%b want 0/0/0", bus.out_valid, vec_cnt, order_err);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (obs_word() !== exp_word()) begin
            failures++;
            $display("FAIL mid_after cyc=%0d got=%h want=%h", c, obs_word(), exp_word());
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.data_in = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_order_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
